// File: rtl/neuromorphic_x1_pkg.sv
// Shared types and constants for the NEUROMORPHIC_X1 Wishbone controller:
// FSM states, register offsets, STATUS bit layout and the STATUS packer.
package neuromorphic_x1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Register offsets taken from wbs_adr_i[3:2]
    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_LAST_RD = 2'd2;

    // STATUS bit positions
    localparam int STAT_OVF = 16;
    localparam int STAT_UNF = 17;
    localparam int STAT_TMO = 18;

    // Pending-entry counter width (holds 0..DEPTH)
    localparam int PEND_W = 6;

    // Assemble the STATUS word; unlisted bits read as zero
    function automatic logic [31:0] pack_status(
        input logic [PEND_W-1:0] pend,
        input logic              ovf,
        input logic              unf,
        input logic              tmo
    );
        logic [31:0] w;
        w               = '0;
        w[PEND_W-1:0]   = pend;
        w[STAT_OVF]     = ovf;
        w[STAT_UNF]     = unf;
        w[STAT_TMO]     = tmo;
        return w;
    endfunction

endpackage

// File: rtl/neuromorphic_x1_wb_ctrl.sv
// Wishbone-classic slave that turns bus accesses into single-outstanding
// requests on the NEUROMORPHIC_X1 ReRAM macro port. Each request is held
// until func_ack (or a timeout), then acknowledged on the bus. Tracks the
// macro's pending-entry count and keeps sticky overflow/underflow/timeout
// flags readable through STATUS.
module neuromorphic_x1_wb_ctrl
    import neuromorphic_x1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH       = 32,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        CLKin,
    input  logic        RSTin,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        EN,
    output logic        R_WB,
    output logic [31:0] DI,
    output logic [31:0] AD,
    output logic [3:0]  SEL,
    input  logic [31:0] DO,
    input  logic        func_ack
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [PEND_W-1:0] DEPTH_P  = PEND_W'(DEPTH);

    state_t             state, state_n;
    logic [PEND_W-1:0]  pending, pending_n;
    logic               ovf, unf, tmo;
    logic               ovf_n, unf_n, tmo_n;
    logic               ovf_set, unf_set, tmo_set;
    logic [2:0]         flag_clr;
    logic [31:0]        last_rd, last_rd_n;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
    logic               en_n, rwb_n, ack_n;
    logic [31:0]        di_n, ad_n, dat_n;
    logic [3:0]         sel_n;
    logic               hit;
    logic [1:0]         off;

    // Pending count never exceeds the macro capacity
    function automatic logic [PEND_W-1:0] sat_inc(input logic [PEND_W-1:0] v);
        return (v >= DEPTH_P) ? DEPTH_P : v + PEND_W'(1);
    endfunction

    // Pending count never wraps below zero
    function automatic logic [PEND_W-1:0] sat_dec(input logic [PEND_W-1:0] v);
        return (v == '0) ? '0 : v - PEND_W'(1);
    endfunction

    assign hit = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off = wbs_adr_i[3:2];

    // Next-state and next-output decode for the whole controller
    always_comb begin
        state_n   = state;
        en_n      = EN;
        rwb_n     = R_WB;
        di_n      = DI;
        ad_n      = AD;
        sel_n     = SEL;
        ack_n     = 1'b0;
        dat_n     = wbs_dat_o;
        last_rd_n = last_rd;
        pending_n = pending;
        tmo_cnt_n = tmo_cnt;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        tmo_set   = 1'b0;
        flag_clr  = 3'b000;

        case (state)
            IDLE: begin
                if (hit) begin
                    case (off)
                        OFF_DATA: begin
                            if (wbs_we_i) begin
                                if (pending < DEPTH_P) begin
                                    di_n      = wbs_dat_i;
                                    ad_n      = wbs_adr_i;
                                    sel_n     = wbs_sel_i;
                                    rwb_n     = 1'b0;
                                    en_n      = 1'b1;
                                    tmo_cnt_n = '0;
                                    state_n   = REQ;
                                end else begin
                                    ovf_set = 1'b1;
                                    dat_n   = '0;
                                    ack_n   = 1'b1;
                                    state_n = RESP;
                                end
                            end else begin
                                if (pending != '0) begin
                                    ad_n      = wbs_adr_i;
                                    sel_n     = wbs_sel_i;
                                    rwb_n     = 1'b1;
                                    en_n      = 1'b1;
                                    tmo_cnt_n = '0;
                                    state_n   = REQ;
                                end else begin
                                    unf_set = 1'b1;
                                    dat_n   = '0;
                                    ack_n   = 1'b1;
                                    state_n = RESP;
                                end
                            end
                        end
                        OFF_STATUS: begin
                            if (wbs_we_i) begin
                                if (wbs_sel_i[2]) begin
                                    flag_clr = {wbs_dat_i[STAT_TMO],
                                                wbs_dat_i[STAT_UNF],
                                                wbs_dat_i[STAT_OVF]};
                                end
                                dat_n = '0;
                            end else begin
                                dat_n = pack_status(pending, ovf, unf, tmo);
                            end
                            ack_n   = 1'b1;
                            state_n = RESP;
                        end
                        OFF_LAST_RD: begin
                            dat_n   = wbs_we_i ? 32'h0 : last_rd;
                            ack_n   = 1'b1;
                            state_n = RESP;
                        end
                        default: begin
                            dat_n   = '0;
                            ack_n   = 1'b1;
                            state_n = RESP;
                        end
                    endcase
                end
            end
            REQ: begin
                if (func_ack) begin
                    en_n    = 1'b0;
                    ack_n   = 1'b1;
                    state_n = RESP;
                    if (R_WB) begin
                        dat_n     = DO;
                        last_rd_n = DO;
                        pending_n = sat_dec(pending);
                    end else begin
                        dat_n     = '0;
                        pending_n = sat_inc(pending);
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    en_n    = 1'b0;
                    tmo_set = 1'b1;
                    dat_n   = '0;
                    ack_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                en_n    = 1'b0;
                state_n = IDLE;
            end
        endcase

        // A set in the same cycle as a clear leaves the flag set
        ovf_n = ovf_set | (ovf & ~flag_clr[0]);
        unf_n = unf_set | (unf & ~flag_clr[1]);
        tmo_n = tmo_set | (tmo & ~flag_clr[2]);
    end

    // FSM state register
    always_ff @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Bus/macro outputs, counters and sticky flags
    always_ff @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            EN        <= 1'b0;
            R_WB      <= 1'b0;
            DI        <= '0;
            AD        <= '0;
            SEL       <= '0;
            pending   <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            tmo       <= 1'b0;
            last_rd   <= '0;
            tmo_cnt   <= '0;
        end else begin
            wbs_ack_o <= ack_n;
            wbs_dat_o <= dat_n;
            EN        <= en_n;
            R_WB      <= rwb_n;
            DI        <= di_n;
            AD        <= ad_n;
            SEL       <= sel_n;
            pending   <= pending_n;
            ovf       <= ovf_n;
            unf       <= unf_n;
            tmo       <= tmo_n;
            last_rd   <= last_rd_n;
            tmo_cnt   <= tmo_cnt_n;
        end
    end

endmodule
